// File: rtl/commit_monitor.sv
// commit_monitor: end-of-run checker that shadows writeback commits and sweeps them against an expected register table.
// Optional trace output is enabled by defining COMMIT_MONITOR_TRACE_EN.
module commit_monitor #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int IDLE_LIMIT = 64,
  parameter int TIMEOUT = 5000,
  parameter int CW = 32,
  localparam int IW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            exp_wr,
  input  logic [IW-1:0]   exp_idx,
  input  logic [XLEN-1:0] exp_data,
  input  logic            commit_valid,
  input  logic            commit_wr,
  input  logic [IW-1:0]   commit_wr_idx,
  input  logic [XLEN-1:0] commit_wr_data,
  input  logic [XLEN-1:0] commit_NPC,
  input  logic [IW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [IW:0]     mismatch_cnt,
  output logic [IW-1:0]   first_bad_idx,
  output logic [CW-1:0]   commit_cnt,
  output logic [CW-1:0]   cycle_cnt,
  output logic [XLEN-1:0] last_NPC
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  state_t          state_q;
  logic [XLEN-1:0] shadow_q [NREGS];
  logic [XLEN-1:0] exp_q [NREGS];
  logic [NREGS-1:0] mask_q;
  logic [CW-1:0]   idle_q, commit_cnt_q, cycle_cnt_q;
  logic [IW-1:0]   ptr_q, first_bad_q;
  logic [IW:0]     mismatch_q;
  logic [XLEN-1:0] last_npc_q;
  logic            done_q, pass_q, timeout_q;
  logic            bad, wr_ok, hit_to, hit_idle, last_ptr;
  assign bad      = mask_q[ptr_q] && shadow_q[ptr_q] != exp_q[ptr_q];
  assign wr_ok    = commit_valid && commit_wr && commit_wr_idx != '0;
  assign hit_to   = cycle_cnt_q == CW'(TIMEOUT - 1);
  assign hit_idle = !commit_valid && idle_q == CW'(IDLE_LIMIT - 1);
  assign last_ptr = ptr_q == IW'(NREGS - 1);
  assign rd_data       = shadow_q[rd_idx];
  assign busy          = state_q == RUN || state_q == CHECK;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign mismatch_cnt  = mismatch_q;
  assign first_bad_idx = first_bad_q;
  assign commit_cnt    = commit_cnt_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign last_NPC      = last_npc_q;
  // expected table has no reset: only masked entries are ever compared
  always_ff @(posedge clk)
    if (state_q == IDLE && exp_wr) exp_q[exp_idx] <= exp_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      shadow_q     <= '{default: '0};
      mask_q       <= '0;
      idle_q       <= '0;
      ptr_q        <= '0;
      first_bad_q  <= '0;
      mismatch_q   <= '0;
      commit_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      last_npc_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exp_wr) mask_q[exp_idx] <= 1'b1;
          if (start) begin
            state_q      <= RUN;
            shadow_q     <= '{default: '0};
            idle_q       <= '0;
            ptr_q        <= '0;
            first_bad_q  <= '0;
            mismatch_q   <= '0;
            commit_cnt_q <= '0;
            cycle_cnt_q  <= '0;
            last_npc_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end
        RUN: begin
          cycle_cnt_q <= cycle_cnt_q + CW'(~&cycle_cnt_q);
          idle_q      <= commit_valid ? '0 : idle_q + CW'(~&idle_q);
          if (commit_valid) begin
            commit_cnt_q <= commit_cnt_q + CW'(~&commit_cnt_q);
            last_npc_q   <= commit_NPC;
          end
          if (wr_ok) shadow_q[commit_wr_idx] <= commit_wr_data;
          if (hit_to) timeout_q <= 1'b1;
          if (hit_to || hit_idle) state_q <= CHECK;
        end
        CHECK: begin
          ptr_q <= ptr_q + IW'(1);
          if (bad) begin
            mismatch_q <= mismatch_q + (IW+1)'(~&mismatch_q);
            if (mismatch_q == '0) first_bad_q <= ptr_q;
          end
          if (last_ptr) begin
            done_q  <= 1'b1;
            pass_q  <= !bad && mismatch_q == '0 && !timeout_q;
            state_q <= DONE;
          end
        end
        default: ;
      endcase
    end
  end
`ifdef COMMIT_MONITOR_TRACE_EN
  always @(posedge clk)
    if (rst) begin
      if (state_q == RUN && commit_valid)
        $display("commit_monitor: cycle %0d npc %h x%0d=%h", cycle_cnt_q, commit_NPC, commit_wr_idx, commit_wr_data);
      if (state_q == CHECK && bad)
        $display("commit_monitor: mismatch x%0d exp %h act %h", ptr_q, exp_q[ptr_q], shadow_q[ptr_q]);
      if (state_q == CHECK && last_ptr)
        $display("commit_monitor: %s commits=%0d cycles=%0d", (!bad && mismatch_q == '0 && !timeout_q) ? "PASS" : "FAIL", commit_cnt_q, cycle_cnt_q);
    end
`else
`endif
endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor: directed self-checking bench for commit_monitor (TIMEOUT shortened to 100).
module tb_commit_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        exp_wr = 1'b0;
  logic [4:0]  exp_idx = '0;
  logic [31:0] exp_data = '0;
  logic        commit_valid = 1'b0;
  logic        commit_wr = 1'b0;
  logic [4:0]  commit_wr_idx = '0;
  logic [31:0] commit_wr_data = '0;
  logic [31:0] commit_NPC = '0;
  logic [4:0]  rd_idx = '0;
  logic [31:0] rd_data;
  logic        busy, done, pass, timeout;
  logic [5:0]  mismatch_cnt;
  logic [4:0]  first_bad_idx;
  logic [31:0] commit_cnt, cycle_cnt, last_NPC;
  int          total = 0;
  int          fails = 0;
  int          n;

  commit_monitor #(.XLEN(32), .NREGS(32), .IDLE_LIMIT(64), .TIMEOUT(100), .CW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_wr(exp_wr), .exp_idx(exp_idx), .exp_data(exp_data),
    .commit_valid(commit_valid), .commit_wr(commit_wr), .commit_wr_idx(commit_wr_idx),
    .commit_wr_data(commit_wr_data), .commit_NPC(commit_NPC), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .mismatch_cnt(mismatch_cnt),
    .first_bad_idx(first_bad_idx), .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt), .last_NPC(last_NPC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic load(input logic [4:0] i, input logic [31:0] d);
    exp_wr = 1'b1; exp_idx = i; exp_data = d;
    tick();
    exp_wr = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic commit(input logic [4:0] i, input logic [31:0] d, input logic [31:0] npc);
    commit_valid = 1'b1; commit_wr = 1'b1; commit_wr_idx = i; commit_wr_data = d; commit_NPC = npc;
    tick();
    commit_valid = 1'b0; commit_wr = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  task automatic read_shadow(input string tag, input logic [4:0] i, input logic [31:0] expv);
    rd_idx = i;
    #1;
    check(tag, rd_data, expv);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_mismatch"}, mismatch_cnt, 0);
    check({tag, "_first_bad"}, first_bad_idx, 0);
    check({tag, "_commit_cnt"}, commit_cnt, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
    check({tag, "_last_npc"}, last_NPC, 0);
  endtask

  initial begin
    do_reset();
    check_cleared("rst");

    // clean run ending on idle
    load(5'd10, 32'h00000179);
    load(5'd11, 32'h00009d80);
    load(5'd12, 32'h00010000);
    go();
    check("t1_busy", busy, 1);
    check("t1_cycle0", cycle_cnt, 0);
    commit(5'd10, 32'h00000179, 32'h00000104);
    commit(5'd11, 32'h00009d80, 32'h00000108);
    commit(5'd12, 32'h00010000, 32'h0000010c);
    read_shadow("t1_rd11", 5'd11, 32'h00009d80);
    wait_done(n);
    check("t1_latency", n, 96);
    check("t1_pass", pass, 1);
    check("t1_mismatch", mismatch_cnt, 0);
    check("t1_commit_cnt", commit_cnt, 3);
    check("t1_cycle_cnt", cycle_cnt, 67);
    check("t1_last_npc", last_NPC, 32'h0000010c);
    check("t1_timeout", timeout, 0);
    check("t1_busy_end", busy, 0);

    // single mismatch; exp_wr/start in RUN must be ignored
    do_reset();
    load(5'd21, 32'h0000007d);
    go();
    commit(5'd21, 32'h0000007c, 32'h00000200);
    exp_wr = 1'b1; exp_idx = 5'd5; exp_data = 32'h00001234; start = 1'b1;
    tick();
    exp_wr = 1'b0; start = 1'b0;
    check("t2_commit_cnt_held", commit_cnt, 1);
    check("t2_cycle_cnt_held", cycle_cnt, 2);
    check("t2_busy", busy, 1);
    wait_done(n);
    check("t2_latency", n, 95);
    check("t2_pass", pass, 0);
    check("t2_mismatch", mismatch_cnt, 1);
    check("t2_first_bad", first_bad_idx, 21);
    read_shadow("t2_rd21", 5'd21, 32'h0000007c);

    // writes to x0 dropped
    do_reset();
    load(5'd0, 32'h00000000);
    go();
    commit(5'd0, 32'hdeadbeef, 32'h00000300);
    read_shadow("t3_rd0", 5'd0, 32'h00000000);
    wait_done(n);
    check("t3_pass", pass, 1);
    check("t3_commit_cnt", commit_cnt, 1);
    check("t3_mismatch", mismatch_cnt, 0);

    // timeout with a commit every cycle
    do_reset();
    go();
    commit_valid = 1'b1; commit_wr = 1'b0; commit_NPC = 32'h00000400;
    wait_done(n);
    commit_valid = 1'b0;
    check("t4_latency", n, 132);
    check("t4_timeout", timeout, 1);
    check("t4_pass", pass, 0);
    check("t4_cycle_cnt", cycle_cnt, 100);
    check("t4_commit_cnt", commit_cnt, 100);

    // two mismatches, then reset mid-CHECK
    do_reset();
    load(5'd5, 32'h00000005);
    load(5'd20, 32'h00000014);
    go();
    commit(5'd5, 32'h00000006, 32'h00000500);
    commit(5'd20, 32'h00000015, 32'h00000504);
    n = 0;
    while (mismatch_cnt != 6'd2 && n < 200) begin
      tick();
      n++;
    end
    check("t5_reached", n < 200, 1);
    check("t5_first_bad", first_bad_idx, 5);
    check("t5_mismatch", mismatch_cnt, 2);
    check("t5_busy", busy, 1);
    check("t5_done", done, 0);
    do_reset();
    check_cleared("t5_rst");
    read_shadow("t5_rd20", 5'd20, 32'h00000000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
